// File: rtl/pair_fetch.sv
`default_nettype none
// ============================================================================
// Module   : pair_fetch
// Purpose  : Stage pair table reader. Takes pair pointers, reads 256-bit words,
//            unpacks the 64-bit slot and returns pairs in request order.
// Revision : 1.0 - initial release
// ============================================================================
module pair_fetch #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int MAX_OUT = 8
) (
    input  logic              eclk,
    input  logic              rstb,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_ptr,
    output logic              req_ready,
    input  logic              cache_inv,
    input  logic              memc_cmd_full,
    output logic              rd_cmd_valid,
    output logic [ADDR_W-1:0] rd_cmd_addr,
    input  logic              rd_data_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_ptr,
    output logic [31:0]       out_idx_lo,
    output logic [31:0]       out_idx_hi,
    output logic              idle
);

    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = ADDR_W + 1;

    localparam logic [0:0] C_IDLE = 1'b0;
    localparam logic [0:0] C_PEND = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [CNT_W-1:0]  credits_q, credits_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic              proto_err_q, proto_err_d;
    logic [ADDR_W-3:0] last_word_q, last_word_d;
    logic              last_valid_q, last_valid_d;
    logic [DATA_W-1:0] cache_word_q, cache_word_d;
    logic [PTR_W:0]    tag_wp_q, tag_wp_d;
    logic [PTR_W:0]    tag_rp_q, tag_rp_d;
    logic [PTR_W:0]    ret_wp_q, ret_wp_d;
    logic [PTR_W:0]    ret_rp_q, ret_rp_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_ptr_q, out_ptr_d;
    logic [31:0]       out_lo_q, out_lo_d;
    logic [31:0]       out_hi_q, out_hi_d;

    // Tag entries are {ptr, hit}; return entries are raw memory words.
    logic [TAG_W-1:0]  tag_mem_q [MAX_OUT];
    logic [DATA_W-1:0] ret_mem_q [MAX_OUT];

    logic              w_tag_empty;
    logic              w_tag_full;
    logic              w_ret_empty;
    logic              w_ret_full;
    logic              w_hit;
    logic              w_req_ready;
    logic              w_accept;
    logic              w_miss_acc;
    logic              w_issue;
    logic              w_ret_err;
    logic              w_ret_push;
    logic [TAG_W-1:0]  w_head;
    logic              w_head_hit;
    logic [ADDR_W-1:0] w_head_ptr;
    logic [DATA_W-1:0] w_word;
    logic [63:0]       w_pair;
    logic              w_head_ready;
    logic              w_out_load;
    logic              w_pop;
    logic              w_miss_pop;

    assign w_tag_empty = (tag_wp_q == tag_rp_q);
    assign w_tag_full  = (tag_wp_q[PTR_W] != tag_rp_q[PTR_W]) &&
                         (tag_wp_q[PTR_W-1:0] == tag_rp_q[PTR_W-1:0]);
    assign w_ret_empty = (ret_wp_q == ret_rp_q);
    assign w_ret_full  = (ret_wp_q[PTR_W] != ret_rp_q[PTR_W]) &&
                         (ret_wp_q[PTR_W-1:0] == ret_rp_q[PTR_W-1:0]);

    // A hit relies only on the last accepted word: the cache will hold that
    // word by the time this entry reaches the head, since the miss that
    // fetched it drains first.
    assign w_hit = last_valid_q && !cache_inv &&
                   (req_ptr[ADDR_W-1:2] == last_word_q);

    assign w_req_ready = !rstb && !w_tag_full && (state_q == C_IDLE) &&
                         ((credits_q != '0) || w_hit);
    assign w_accept    = req_valid && w_req_ready;
    assign w_miss_acc  = w_accept && !w_hit;
    assign w_issue     = !rstb && (state_q == C_PEND) && !memc_cmd_full;

    // Returns with nothing outstanding are dropped, and so is everything after.
    assign w_ret_err  = rd_data_valid && (inflight_q == '0);
    assign w_ret_push = !rstb && rd_data_valid && !w_ret_err &&
                        !proto_err_q && !w_ret_full;

    assign w_head       = tag_mem_q[tag_rp_q[PTR_W-1:0]];
    assign w_head_hit   = w_head[0];
    assign w_head_ptr   = w_head[TAG_W-1:1];
    assign w_word       = w_head_hit ? cache_word_q : ret_mem_q[ret_rp_q[PTR_W-1:0]];
    assign w_head_ready = !w_tag_empty && (w_head_hit || !w_ret_empty);
    assign w_out_load   = !out_valid_q || out_ready;
    assign w_pop        = w_out_load && w_head_ready;
    assign w_miss_pop   = w_pop && !w_head_hit;

    always_comb begin
        w_pair = w_word[63:0];
        case (w_head_ptr[1:0])
            2'd0:    w_pair = w_word[63:0];
            2'd1:    w_pair = w_word[127:64];
            2'd2:    w_pair = w_word[191:128];
            default: w_pair = w_word[255:192];
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cmd_addr_d   = cmd_addr_q;
        credits_d    = credits_q;
        inflight_d   = inflight_q;
        proto_err_d  = proto_err_q | w_ret_err;
        last_word_d  = last_word_q;
        last_valid_d = last_valid_q;
        cache_word_d = cache_word_q;
        tag_wp_d     = tag_wp_q;
        tag_rp_d     = tag_rp_q;
        ret_wp_d     = ret_wp_q;
        ret_rp_d     = ret_rp_q;
        out_valid_d  = out_valid_q;
        out_ptr_d    = out_ptr_q;
        out_lo_d     = out_lo_q;
        out_hi_d     = out_hi_q;

        case (state_q)
            C_IDLE: begin
                if (w_miss_acc) begin
                    state_d    = C_PEND;
                    cmd_addr_d = {2'b00, req_ptr[ADDR_W-1:2]};
                end
            end
            C_PEND: begin
                if (w_issue) begin
                    state_d = C_IDLE;
                end
            end
            default: state_d = C_IDLE;
        endcase

        case ({w_miss_acc, w_miss_pop})
            2'b10:   credits_d = credits_q - CNT_W'(1);
            2'b01:   credits_d = credits_q + CNT_W'(1);
            default: credits_d = credits_q;
        endcase

        case ({w_issue, w_ret_push})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        if (w_accept) begin
            last_word_d  = req_ptr[ADDR_W-1:2];
            last_valid_d = 1'b1;
            tag_wp_d     = tag_wp_q + (PTR_W+1)'(1);
        end else if (cache_inv) begin
            last_valid_d = 1'b0;
        end

        if (w_ret_push) begin
            ret_wp_d = ret_wp_q + (PTR_W+1)'(1);
        end

        if (w_pop) begin
            tag_rp_d = tag_rp_q + (PTR_W+1)'(1);
        end

        if (w_miss_pop) begin
            ret_rp_d     = ret_rp_q + (PTR_W+1)'(1);
            cache_word_d = w_word;
        end

        if (w_out_load) begin
            out_valid_d = w_head_ready;
            if (w_head_ready) begin
                out_ptr_d = w_head_ptr;
                out_hi_d  = w_pair[63:32];
                out_lo_d  = w_pair[31:0];
            end
        end
    end

    always_ff @(posedge eclk) begin
        if (rstb) begin
            state_q      <= C_IDLE;
            cmd_addr_q   <= '0;
            credits_q    <= CNT_W'(MAX_OUT);
            inflight_q   <= '0;
            proto_err_q  <= 1'b0;
            last_word_q  <= '0;
            last_valid_q <= 1'b0;
            cache_word_q <= '0;
            tag_wp_q     <= '0;
            tag_rp_q     <= '0;
            ret_wp_q     <= '0;
            ret_rp_q     <= '0;
            out_valid_q  <= 1'b0;
            out_ptr_q    <= '0;
            out_lo_q     <= '0;
            out_hi_q     <= '0;
        end else begin
            state_q      <= state_d;
            cmd_addr_q   <= cmd_addr_d;
            credits_q    <= credits_d;
            inflight_q   <= inflight_d;
            proto_err_q  <= proto_err_d;
            last_word_q  <= last_word_d;
            last_valid_q <= last_valid_d;
            cache_word_q <= cache_word_d;
            tag_wp_q     <= tag_wp_d;
            tag_rp_q     <= tag_rp_d;
            ret_wp_q     <= ret_wp_d;
            ret_rp_q     <= ret_rp_d;
            out_valid_q  <= out_valid_d;
            out_ptr_q    <= out_ptr_d;
            out_lo_q     <= out_lo_d;
            out_hi_q     <= out_hi_d;
        end
    end

    always_ff @(posedge eclk) begin
        if (w_accept) begin
            tag_mem_q[tag_wp_q[PTR_W-1:0]] <= {req_ptr, w_hit};
        end
        if (w_ret_push) begin
            ret_mem_q[ret_wp_q[PTR_W-1:0]] <= rd_data;
        end
    end

    assign req_ready    = w_req_ready;
    assign rd_cmd_valid = w_issue;
    assign rd_cmd_addr  = cmd_addr_q;
    assign out_valid    = out_valid_q;
    assign out_ptr      = out_ptr_q;
    assign out_idx_lo   = out_lo_q;
    assign out_idx_hi   = out_hi_q;
    assign idle         = w_tag_empty && w_ret_empty && (state_q == C_IDLE) && !out_valid_q;

endmodule
`default_nettype wire
